// File: rtl/mem_byte_serializer_pkg.sv
// Shared encodings for the byte-serial memory engine: length codes, IO-region
// select defaults, FSM state and the latched request record.
package mem_byte_serializer_pkg;

  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;

  localparam int         IO_SEL_HI_DEF  = 17;
  localparam int         IO_SEL_LO_DEF  = 16;
  localparam logic [1:0] IO_SEL_VAL_DEF = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
  } req_t;

  // Size code 11 is not a legal access; it is handled as a full word.
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      LEN_B[1:0]: return 3'd1;
      LEN_H[1:0]: return 3'd2;
      LEN_W[1:0]: return 3'd4;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_serializer_if.sv
// Request/response handshake toward the arbiter plus the 8-bit RAM/IO bus.
interface mem_byte_serializer_if;
  logic        valid;
  logic        wr;
  logic [31:0] addr;
  logic [2:0]  len;
  logic [31:0] data;
  logic        ready;
  logic [31:0] res;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave  (input  valid, wr, addr, len, data, mem_din, io_buffer_full,
                  output ready, res, mem_dout, mem_a, mem_wr);
  modport master (output valid, wr, addr, len, data, mem_din, io_buffer_full,
                  input  ready, res, mem_dout, mem_a, mem_wr);
endinterface

// File: rtl/mem_byte_serializer_load_extend.sv
// Combinational load result formatting: sign/zero extension of the gathered bytes.
module mem_byte_serializer_load_extend
  import mem_byte_serializer_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  len,
  output logic [31:0] res
);
  always_comb begin
    case (len)
      LEN_B:   res = {{24{raw[7]}}, raw[7:0]};
      LEN_BU:  res = {24'd0, raw[7:0]};
      LEN_H:   res = {{16{raw[15]}}, raw[15:0]};
      LEN_HU:  res = {16'd0, raw[15:0]};
      default: res = raw;
    endcase
  end
endmodule

// File: rtl/mem_byte_serializer.sv
// Byte-serial engine: one 1/2/4-byte request at a time, one byte per cycle on
// the 8-bit bus, little-endian reassembly of reads, IO write back-pressure.
module mem_byte_serializer
  import mem_byte_serializer_pkg::*;
#(
  parameter int                           IO_SEL_HI  = IO_SEL_HI_DEF,
  parameter int                           IO_SEL_LO  = IO_SEL_LO_DEF,
  parameter logic [IO_SEL_HI-IO_SEL_LO:0] IO_SEL_VAL = IO_SEL_VAL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  mem_byte_serializer_if.slave bus
);
  state_t      state, state_nx;
  req_t        req;
  logic [2:0]  idx, recv, n;
  logic [31:0] rbuf, a_q, ext;
  logic [7:0]  dout_q, wbyte;
  logic        stall, issue, capture;

  mem_byte_serializer_load_extend u_ext (.raw(rbuf), .len(req.len), .res(ext));

  always_comb begin
    n       = nbytes(req.len[1:0]);
    stall   = req.wr && (req.addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL) && bus.io_buffer_full;
    issue   = (state == BUSY) && (idx < n) && !stall;
    // A read byte is in flight whenever more bytes were issued than captured.
    capture = (state == BUSY) && !req.wr && (recv < idx);
    case (idx[1:0])
      2'd0:    wbyte = req.data[7:0];
      2'd1:    wbyte = req.data[15:8];
      2'd2:    wbyte = req.data[23:16];
      default: wbyte = req.data[31:24];
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.valid) state_nx = BUSY;
      BUSY:    if ((req.wr && issue && idx == n - 3'd1) || (capture && recv == n - 3'd1))
                 state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_a = a_q;
    if (issue) bus.mem_a = req.addr + {29'd0, idx};
    // While frozen, keep presenting the in-flight read address so its byte is
    // on mem_din again in the cycle rdy returns.
    if (!rdy && capture) bus.mem_a = req.addr + {29'd0, recv};
    bus.mem_wr   = issue && req.wr && rdy && !rst;
    bus.mem_dout = (issue && req.wr) ? wbyte : dout_q;
    bus.ready    = (state == DONE) && rdy;
    bus.res      = ((state == DONE) && !req.wr) ? ext : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req    <= '0;
      idx    <= '0;
      recv   <= '0;
      rbuf   <= '0;
      a_q    <= '0;
      dout_q <= '0;
    end else if (rdy) begin
      state <= state_nx;
      if (state == IDLE && bus.valid) begin
        req  <= '{bus.wr, bus.addr, bus.len, bus.data};
        idx  <= '0;
        recv <= '0;
        rbuf <= '0;
      end
      if (issue) begin
        idx <= idx + 3'd1;
        a_q <= req.addr + {29'd0, idx};
        if (req.wr) dout_q <= wbyte;
      end
      if (capture) begin
        rbuf[{recv[1:0], 3'b000} +: 8] <= bus.mem_din;
        recv <= recv + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_byte_serializer.sv
// Directed table-driven bench for mem_byte_serializer with a 1-cycle-latency RAM model.
module tb_mem_byte_serializer;
  import mem_byte_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy;
  mem_byte_serializer_if bus();

  mem_byte_serializer dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];

  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[15:0]];
    if (bus.mem_wr) ram[bus.mem_a[15:0]] = bus.mem_dout;
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nb_of(input logic [2:0] l);
    return (l[1:0] == 2'b00) ? 1 : (l[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Cycle 0 is the accept cycle. full_m / frz_m give per-cycle io_buffer_full
  // and rdy=0 patterns. Write bytes are checked as they appear on the bus.
  task automatic do_req(input string name, input logic w, input logic [2:0] l,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [15:0] full_m, input logic [15:0] frz_m, input bit short_v,
                        output int lat, output logic [31:0] r, output int nwr, output int first_wr);
    bit seen;
    seen = 0; lat = -1; r = '0; nwr = 0; first_wr = -1;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus.valid = short_v ? (c == 0) : 1'b1;
      bus.wr = w; bus.len = l; bus.addr = a; bus.data = d;
      bus.io_buffer_full = (c < 16) ? full_m[c] : 1'b0;
      rdy = (c < 16) ? !frz_m[c] : 1'b1;
      @(negedge clk);
      if (bus.mem_wr) begin
        if (first_wr < 0) first_wr = c;
        chk($sformatf("%s mem_a b%0d", name, nwr), bus.mem_a, a + 32'(nwr));
        if (nwr < 4)
          chk($sformatf("%s dout b%0d", name, nwr), {24'd0, bus.mem_dout}, {24'd0, d[8*nwr +: 8]});
        nwr++;
      end
      if (bus.ready) begin
        seen = 1; lat = c; r = bus.res;
        chk({name, " mem_wr_at_ready"}, {31'd0, bus.mem_wr}, 32'd0);
      end
    end
    chk({name, " ready_seen"}, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.io_buffer_full = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk({name, " one_pulse"}, {31'd0, bus.ready}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  l;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t tv [12];

  initial begin
    int lat, nwr, fw, nb;
    logic [31:0] r;
    logic [15:0] ix;

    tv[0]  = '{1'b1, LEN_W,  32'h0000_1000, 32'h1122_3344, 32'h0000_0000, 5};
    tv[1]  = '{1'b1, LEN_H,  32'h0000_1010, 32'hAAAA_BEEF, 32'h0000_0000, 3};
    tv[2]  = '{1'b1, LEN_B,  32'h0000_1020, 32'h0000_005A, 32'h0000_0000, 2};
    tv[3]  = '{1'b0, LEN_B,  32'h0000_0020, 32'h0,         32'hFFFF_FF80, 3};
    tv[4]  = '{1'b0, LEN_BU, 32'h0000_0020, 32'h0,         32'h0000_0080, 3};
    tv[5]  = '{1'b0, LEN_H,  32'h0000_0022, 32'h0,         32'hFFFF_9234, 4};
    tv[6]  = '{1'b0, LEN_HU, 32'h0000_0022, 32'h0,         32'h0000_9234, 4};
    tv[7]  = '{1'b0, LEN_W,  32'h0000_0040, 32'h0,         32'h1234_5678, 6};
    tv[8]  = '{1'b0, 3'b011, 32'h0000_0040, 32'h0,         32'h1234_5678, 6};
    tv[9]  = '{1'b0, LEN_W,  32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA, 6};
    tv[10] = '{1'b0, LEN_B,  32'h0000_0050, 32'h0,         32'h0000_007F, 3};
    tv[11] = '{1'b0, LEN_H,  32'h0000_0052, 32'h0,         32'hFFFF_8000, 4};

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0020] = 8'h80;
    ram[16'h0022] = 8'h34; ram[16'h0023] = 8'h92;
    ram[16'h0040] = 8'h78; ram[16'h0041] = 8'h56; ram[16'h0042] = 8'h34; ram[16'h0043] = 8'h12;
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB; ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;
    ram[16'h0050] = 8'h7F;
    ram[16'h0052] = 8'h00; ram[16'h0053] = 8'h80;

    rst = 1'b1; rdy = 1'b1;
    bus.valid = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.len = '0; bus.data = '0;
    bus.io_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready",    {31'd0, bus.ready},    32'd0);
    chk("rst res",      bus.res,               32'd0);
    chk("rst mem_wr",   {31'd0, bus.mem_wr},   32'd0);
    chk("rst mem_a",    bus.mem_a,             32'd0);
    chk("rst mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_req($sformatf("v%0d", i), tv[i].w, tv[i].l, tv[i].a, tv[i].d, 16'h0, 16'h0, 1'b0,
             lat, r, nwr, fw);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tv[i].exp_lat));
      chk($sformatf("v%0d res", i), r, tv[i].exp_r);
      nb = nb_of(tv[i].l);
      if (tv[i].w) begin
        chk($sformatf("v%0d write_count", i), 32'(nwr), 32'(nb));
        chk($sformatf("v%0d first_write", i), 32'(fw), 32'd1);
        for (int b = 0; b < nb; b++) begin
          ix = tv[i].a[15:0] + 16'(b);
          chk($sformatf("v%0d ram b%0d", i, b), {24'd0, ram[ix]}, {24'd0, tv[i].d[8*b +: 8]});
        end
      end else begin
        chk($sformatf("v%0d no_writes", i), 32'(nwr), 32'd0);
      end
    end

    // IO write held off by a full buffer in cycles 1-3.
    do_req("sb_io", 1'b1, LEN_B, 32'h0003_0000, 32'h0000_0041, 16'b1110, 16'h0, 1'b0, lat, r, nwr, fw);
    chk("sb_io latency", 32'(lat), 32'd5);
    chk("sb_io first_write", 32'(fw), 32'd4);
    chk("sb_io write_count", 32'(nwr), 32'd1);
    chk("sb_io ram", {24'd0, ram[16'h0000]}, 32'h41);

    // Reads and non-IO writes ignore io_buffer_full.
    do_req("lb_io_full", 1'b0, LEN_B, 32'h0003_0000, 32'h0, 16'hFFFF, 16'h0, 1'b0, lat, r, nwr, fw);
    chk("lb_io_full latency", 32'(lat), 32'd3);
    chk("lb_io_full res", r, 32'h0000_0041);
    do_req("sb_nonio_full", 1'b1, LEN_B, 32'h0002_0000, 32'h0000_0099, 16'hFFFF, 16'h0, 1'b0, lat, r, nwr, fw);
    chk("sb_nonio_full latency", 32'(lat), 32'd2);
    chk("sb_nonio_full ram", {24'd0, ram[16'h0000]}, 32'h99);

    // Freeze during a word load and during a word store.
    do_req("lw_frz", 1'b0, LEN_W, 32'h0000_0040, 32'h0, 16'h0, 16'b11100, 1'b0, lat, r, nwr, fw);
    chk("lw_frz latency", 32'(lat), 32'd9);
    chk("lw_frz res", r, 32'h1234_5678);
    do_req("sw_frz", 1'b1, LEN_W, 32'h0000_1100, 32'hCAFE_F00D, 16'h0, 16'b00100, 1'b0, lat, r, nwr, fw);
    chk("sw_frz latency", 32'(lat), 32'd6);
    chk("sw_frz write_count", 32'(nwr), 32'd4);
    chk("sw_frz ram", {ram[16'h1103], ram[16'h1102], ram[16'h1101], ram[16'h1100]}, 32'hCAFE_F00D);

    // valid dropped after the accept cycle: request still completes.
    do_req("lh_short", 1'b0, LEN_H, 32'h0000_0022, 32'h0, 16'h0, 16'h0, 1'b1, lat, r, nwr, fw);
    chk("lh_short latency", 32'(lat), 32'd4);
    chk("lh_short res", r, 32'hFFFF_9234);

    // rst in cycle 2 of a word load.
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.wr = 1'b0; bus.len = LEN_W; bus.addr = 32'h0000_0040; bus.data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid mem_wr_in_rst", {31'd0, bus.mem_wr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.valid = 1'b0;
    @(negedge clk);
    chk("rst_mid ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_mid mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_mid mem_a_idle", bus.mem_a, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid ready_later", {31'd0, bus.ready}, 32'd0);
    do_req("sh_after_rst", 1'b1, LEN_H, 32'h0000_1200, 32'h0000_A55A, 16'h0, 16'h0, 1'b0, lat, r, nwr, fw);
    chk("sh_after_rst latency", 32'(lat), 32'd3);
    chk("sh_after_rst ram", {16'd0, ram[16'h1201], ram[16'h1200]}, 32'h0000_A55A);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
